digit_feedback_display: RTL and testbench

DIGIT_FEEDBACK_DISPLAY -- requirements
Module: digit_feedback_display

---
 rtl/digit_feedback_display.sv | 244 ++++++++++++++++++++++++
 tb/tb_digit_feedback_display.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_feedback_display.sv
// Seven-segment character and LED driver for the digit-guessing game: per-state
// display composition, a blink generator and a paced bulls/cows reveal sequencer.
package game_types;
    typedef enum logic [3:0] {
        S_IDLE,
        S_SET_ENTER,
        S_SET_CHECK,
        S_GUESS_ENTER,
        S_GUESS_CHECK,
        S_SCORE,
        S_SHOW_RESULT,
        S_WIN,
        S_LOSE
    } state_t;
endpackage

module digit_feedback_display
    import game_types::*;
#(
    parameter int N_DIG     = 4,
    parameter int MAX_CH    = 5,
    parameter int BLINK_CYC = 25_000_000,
    parameter int STEP_CYC  = 12_500_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  state_t                     state,
    input  logic [$clog2(N_DIG)-1:0]   cursor,
    input  logic [4*N_DIG-1:0]         target,
    input  logic [4*N_DIG-1:0]         guess,
    input  logic [N_DIG-1:0]           is_random,
    input  logic [3:0]                 candidate,
    input  logic                       sw_valid,
    input  logic [2:0]                 chances,
    input  logic                       reveal_start,
    output logic                       reveal_done,
    output logic [2:0]                 bulls,
    output logic [2:0]                 cows,
    output logic [4*N_DIG-1:0]         char_out,
    output logic [N_DIG+MAX_CH-1:0]    led
);

    localparam int CW = $clog2(N_DIG);
    localparam int DW = 4 * N_DIG;
    localparam int LW = N_DIG + MAX_CH;
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam int SW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_STEP = 2'd1;
    localparam logic [1:0] R_DONE = 2'd2;

    localparam logic [3:0] CH_L     = 4'hD;
    localparam logic [3:0] CH_O     = 4'h0;
    localparam logic [3:0] CH_S     = 4'h5;
    localparam logic [3:0] CH_E     = 4'hE;
    localparam logic [3:0] CH_A     = 4'hA;
    localparam logic [3:0] CH_B     = 4'hB;
    localparam logic [3:0] CH_U     = 4'hC;
    localparam logic [3:0] CH_BLANK = 4'hF;

    logic            blink_q, blink_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    state_t          prev_q;
    logic [1:0]      rev_q, rev_d;
    logic [SW-1:0]   step_q, step_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   snap_g_q, snap_g_d, snap_t_q, snap_t_d;
    logic [N_DIG-1:0] fb_bull_q, fb_bull_d, fb_cow_q, fb_cow_d, rvl_q, rvl_d;
    logic [2:0]      bulls_q, bulls_d, cows_q, cows_d;
    logic [DW-1:0]   char_q, char_d;
    logic [LW-1:0]   led_q, led_d;

    logic [3:0]      g_dig;
    logic            cow_hit;
    int              cur, chc;
    logic [3:0]      dig;
    logic [15:0]     pat;
    logic [DW-1:0]   shown;

    // Blink generator and reveal sequencer next-state.
    always_comb begin
        // NOTE: every comb-assigned signal gets a default first so no path leaves it unassigned (no latch).
        blink_d   = blink_q;
        bcnt_d    = bcnt_q;
        rev_d     = rev_q;
        step_d    = step_q;
        idx_d     = idx_q;
        snap_g_d  = snap_g_q;
        snap_t_d  = snap_t_q;
        fb_bull_d = fb_bull_q;
        fb_cow_d  = fb_cow_q;
        rvl_d     = rvl_q;
        bulls_d   = bulls_q;
        cows_d    = cows_q;
        g_dig     = 4'h0;
        cow_hit   = 1'b0;

        if (state != prev_q) begin
            bcnt_d  = '0;
            blink_d = 1'b1;
        end else if (bcnt_q == BW'(BLINK_CYC - 1)) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
        end else begin
            bcnt_d = bcnt_q + BW'(1);
        end

        if (state != S_SHOW_RESULT) begin
            rev_d     = R_IDLE;
            fb_bull_d = '0;
            fb_cow_d  = '0;
            rvl_d     = '0;
        end else begin
            case (rev_q)
                R_IDLE: if (reveal_start) begin
                    rev_d     = R_STEP;
                    snap_g_d  = guess;
                    snap_t_d  = target;
                    idx_d     = CW'(N_DIG - 1);
                    bulls_d   = '0;
                    cows_d    = '0;
                    fb_bull_d = '0;
                    fb_cow_d  = '0;
                    rvl_d     = '0;
                    step_d    = '0;
                end
                R_STEP: if (step_q == SW'(STEP_CYC - 1)) begin
                    g_dig = snap_g_q[4*idx_q +: 4];
                    for (int j = 0; j < N_DIG; j++) begin
                        if (j != int'(idx_q) && snap_t_q[4*j +: 4] == g_dig) cow_hit = 1'b1;
                    end
                    if (g_dig == snap_t_q[4*idx_q +: 4]) begin
                        bulls_d          = bulls_q + 3'd1;
                        fb_bull_d[idx_q] = 1'b1;
                    end else if (cow_hit) begin
                        cows_d          = cows_q + 3'd1;
                        fb_cow_d[idx_q] = 1'b1;
                    end
                    rvl_d[idx_q] = 1'b1;
                    step_d       = '0;
                    if (idx_q == '0) rev_d = R_DONE;
                    else             idx_d = idx_q - CW'(1);
                end else begin
                    step_d = step_q + SW'(1);
                end
                R_DONE: ;
                default: rev_d = R_IDLE;
            endcase
        end
    end

    // Display composition; the result is registered below.
    always_comb begin
        char_d = {N_DIG{CH_BLANK}};
        led_d  = '0;
        cur    = int'(cursor);
        if (cur >= N_DIG) cur = N_DIG - 1;
        chc    = int'(chances);
        if (chc > MAX_CH) chc = MAX_CH;
        dig    = CH_BLANK;
        pat    = {4{CH_BLANK}};
        shown  = (rev_q == R_IDLE) ? guess : snap_g_q;

        case (state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (state == S_IDLE)     pat = {4'h1, CH_A, 4'h2, CH_B};
                else if (state == S_WIN) pat = {4'(N_DIG), CH_A, CH_O, CH_B};
                else                     pat = {CH_L, CH_O, CH_S, CH_E};
                for (int k = 0; k < 4; k++) char_d[4*(N_DIG-1-k) +: 4] = pat[15-4*k -: 4];
                led_d = {LW{blink_q}};
            end
            S_SET_ENTER, S_SET_CHECK, S_GUESS_ENTER, S_GUESS_CHECK: begin
                for (int i = 0; i < N_DIG; i++) begin
                    if (i > cur)
                        dig = (state inside {S_GUESS_ENTER, S_GUESS_CHECK}) ? guess[4*i +: 4]
                            : (is_random[i] ? CH_U : target[4*i +: 4]);
                    else if (i == cur)
                        dig = blink_q ? (sw_valid ? candidate : CH_U) : CH_BLANK;
                    else
                        dig = CH_U;
                    char_d[4*i +: 4] = dig;
                end
                if (state inside {S_GUESS_ENTER, S_GUESS_CHECK}) begin
                    for (int i = 0; i < MAX_CH; i++) begin
                        if (i == chc - 1)    led_d[i] = blink_q;
                        else if (i < chc - 1) led_d[i] = 1'b1;
                    end
                end
            end
            S_SHOW_RESULT: begin
                char_d = shown;
                for (int i = 0; i < MAX_CH; i++) led_d[i] = (i < chc);
                for (int i = 0; i < N_DIG; i++)
                    led_d[MAX_CH+i] = rvl_q[i] & (fb_bull_q[i] | (fb_cow_q[i] & blink_q));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q   <= 1'b0;
            bcnt_q    <= '0;
            prev_q    <= S_IDLE;
            rev_q     <= R_IDLE;
            step_q    <= '0;
            idx_q     <= '0;
            snap_g_q  <= '0;
            snap_t_q  <= '0;
            fb_bull_q <= '0;
            fb_cow_q  <= '0;
            rvl_q     <= '0;
            bulls_q   <= '0;
            cows_q    <= '0;
            char_q    <= {N_DIG{CH_BLANK}};
            led_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            blink_q   <= blink_d;
            bcnt_q    <= bcnt_d;
            prev_q    <= state;
            rev_q     <= rev_d;
            step_q    <= step_d;
            idx_q     <= idx_d;
            snap_g_q  <= snap_g_d;
            snap_t_q  <= snap_t_d;
            fb_bull_q <= fb_bull_d;
            fb_cow_q  <= fb_cow_d;
            rvl_q     <= rvl_d;
            bulls_q   <= bulls_d;
            cows_q    <= cows_d;
            char_q    <= char_d;
            led_q     <= led_d;
        end
    end

    assign reveal_done = (rev_q == R_DONE);
    assign bulls       = bulls_q;
    assign cows        = cows_q;
    assign char_out    = char_q;
    assign led         = led_q;

endmodule

// File: tb/tb_digit_feedback_display.sv
// Bench for digit_feedback_display: table of static display vectors scored against a
// blink-phase model, plus hand-written reveal, abort and reset sequences.
module tb_digit_feedback_display;
    import game_types::*;

    localparam int N_DIG  = 4;
    localparam int MAX_CH = 5;
    localparam int BLINK  = 4;
    localparam int STEP   = 2;

    logic        clk = 1'b0;
    logic        rst;
    state_t      state;
    logic [1:0]  cursor;
    logic [15:0] target, guess;
    logic [3:0]  is_random, candidate;
    logic        sw_valid;
    logic [2:0]  chances;
    logic        reveal_start;
    logic        reveal_done;
    logic [2:0]  bulls, cows;
    logic [15:0] char_out;
    logic [8:0]  led;

    digit_feedback_display #(
        .N_DIG(N_DIG), .MAX_CH(MAX_CH), .BLINK_CYC(BLINK), .STEP_CYC(STEP)
    ) dut (
        .clk(clk), .rst(rst), .state(state), .cursor(cursor), .target(target),
        .guess(guess), .is_random(is_random), .candidate(candidate), .sw_valid(sw_valid),
        .chances(chances), .reveal_start(reveal_start), .reveal_done(reveal_done),
        .bulls(bulls), .cows(cows), .char_out(char_out), .led(led)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        state_t      st;
        logic [1:0]  cur;
        logic [15:0] tgt;
        logic [15:0] gs;
        logic [3:0]  rnd;
        logic [3:0]  cand;
        logic        vld;
        logic [2:0]  ch;
        int          ncyc;
        logic [15:0] ch_on;
        logic [15:0] ch_off;
        logic [8:0]  led_on;
        logic [8:0]  led_off;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] ch;
        logic [8:0]  led;
    } exp_t;

    vec_t   vecs[11];
    exp_t   sb[$];
    int     total = 0;
    int     bad   = 0;

    logic   m_blink;
    int     m_cnt;
    state_t m_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_blink = 1'b0;
        m_cnt   = 0;
        m_prev  = S_IDLE;
    endtask

    // Blink phase as seen by the display in the coming cycle.
    task automatic model_tick();
        if (state != m_prev) begin
            m_cnt   = 0;
            m_blink = 1'b1;
        end else if (m_cnt == BLINK - 1) begin
            m_cnt   = 0;
            m_blink = ~m_blink;
        end else begin
            m_cnt++;
        end
        m_prev = state;
    endtask

    task automatic apply_vec(input vec_t v);
        exp_t e, o;
        state     = v.st;
        cursor    = v.cur;
        target    = v.tgt;
        guess     = v.gs;
        is_random = v.rnd;
        candidate = v.cand;
        sw_valid  = v.vld;
        chances   = v.ch;
        for (int n = 0; n < v.ncyc; n++) begin
            e.name = v.name;
            e.ch   = m_blink ? v.ch_on : v.ch_off;
            e.led  = m_blink ? v.led_on : v.led_off;
            sb.push_back(e);
            model_tick();
            tick();
            o = sb.pop_front();
            check({o.name, "/char"}, 32'(char_out), 32'(o.ch));
            check({o.name, "/led"}, 32'(led), 32'(o.led));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_hi, seen_lo;
        logic [2:0] exp_b[1:8];
        logic [2:0] exp_c[1:8];

        vecs[0]  = '{"idle",      S_IDLE,        2'd0, 16'h0000, 16'h0000, 4'b0000, 4'h0, 1'b0, 3'd0, 20, 16'h1A2B, 16'h1A2B, 9'h1FF, 9'h000};
        vecs[1]  = '{"set_rand",  S_SET_ENTER,   2'd2, 16'h5678, 16'h0000, 4'b1000, 4'h4, 1'b1, 3'd0, 10, 16'hC4CC, 16'hCFCC, 9'h000, 9'h000};
        vecs[2]  = '{"set_inval", S_SET_CHECK,   2'd1, 16'h5678, 16'h0000, 4'b0000, 4'h9, 1'b0, 3'd0, 10, 16'h56CC, 16'h56FC, 9'h000, 9'h000};
        vecs[3]  = '{"guess_c3",  S_GUESS_ENTER, 2'd1, 16'h0000, 16'h3700, 4'b1111, 4'h9, 1'b1, 3'd3, 10, 16'h379C, 16'h37FC, 9'h007, 9'h003};
        vecs[4]  = '{"guess_c7",  S_GUESS_CHECK, 2'd3, 16'h0000, 16'h0000, 4'b0000, 4'h2, 1'b1, 3'd7, 10, 16'h2CCC, 16'hFCCC, 9'h01F, 9'h00F};
        vecs[5]  = '{"guess_c0",  S_GUESS_ENTER, 2'd0, 16'h0000, 16'h9876, 4'b0000, 4'h1, 1'b1, 3'd0, 10, 16'h9871, 16'h987F, 9'h000, 9'h000};
        vecs[6]  = '{"guess_c1",  S_GUESS_ENTER, 2'd0, 16'h0000, 16'h9876, 4'b0000, 4'h1, 1'b1, 3'd1, 10, 16'h9871, 16'h987F, 9'h001, 9'h000};
        vecs[7]  = '{"win",       S_WIN,         2'd0, 16'h0000, 16'h0000, 4'b0000, 4'h0, 1'b0, 3'd0, 10, 16'h4A0B, 16'h4A0B, 9'h1FF, 9'h000};
        vecs[8]  = '{"lose",      S_LOSE,        2'd0, 16'h0000, 16'h0000, 4'b0000, 4'h0, 1'b0, 3'd0, 10, 16'hD05E, 16'hD05E, 9'h1FF, 9'h000};
        vecs[9]  = '{"unlisted",  S_SCORE,       2'd0, 16'h1234, 16'h1325, 4'b0000, 4'h0, 1'b0, 3'd2, 6,  16'hFFFF, 16'hFFFF, 9'h000, 9'h000};
        vecs[10] = '{"result",    S_SHOW_RESULT, 2'd0, 16'h1234, 16'h1325, 4'b0000, 4'h0, 1'b0, 3'd2, 6,  16'h1325, 16'h1325, 9'h003, 9'h003};

        exp_b = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        exp_c = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2};

        rst = 1'b1; state = S_IDLE; cursor = '0; target = '0; guess = '0;
        is_random = '0; candidate = '0; sw_valid = 1'b0; chances = '0; reveal_start = 1'b0;
        model_reset();
        repeat (3) tick();
        check("rst_char", 32'(char_out), 32'h0000_FFFF);
        check("rst_led", 32'(led), 32'h0);
        check("rst_bulls", 32'(bulls), 32'h0);
        check("rst_cows", 32'(cows), 32'h0);
        check("rst_done", 32'(reveal_done), 32'h0);
        rst = 1'b0;

        for (int v = 0; v < 11; v++) apply_vec(vecs[v]);

        // Paced reveal of 1325 against 1234; a second start pulse lands mid-reveal.
        reveal_start = 1'b1;
        tick();
        reveal_start = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            if (t == 3) reveal_start = 1'b1;
            if (t == 5) guess = 16'h9999;
            tick();
            reveal_start = 1'b0;
            check($sformatf("rev_bulls_t%0d", t), 32'(bulls), 32'(exp_b[t]));
            check($sformatf("rev_cows_t%0d", t), 32'(cows), 32'(exp_c[t]));
            check($sformatf("rev_done_t%0d", t), 32'(reveal_done), (t == 8) ? 32'h1 : 32'h0);
            if (t == 3) check("rev_left_first", 32'(led[8:5]), 32'h8);
            if (t >= 5) check($sformatf("rev_snapshot_t%0d", t), 32'(char_out), 32'h1325);
        end

        seen_hi = 1'b0;
        seen_lo = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (n == 2) reveal_start = 1'b1;
            tick();
            reveal_start = 1'b0;
            check("fb_bull_solid", 32'(led[8]), 32'h1);
            check("fb_none_off", 32'(led[5]), 32'h0);
            check("fb_cows_same", 32'(led[7]), 32'(led[6]));
            check("fb_chance_bar", 32'(led[4:0]), 32'h3);
            check("done_level", 32'(reveal_done), 32'h1);
            if (led[7]) seen_hi = 1'b1;
            else        seen_lo = 1'b1;
        end
        check("fb_cow_blinks", 32'({seen_hi, seen_lo}), 32'h3);
        check("done_bulls_hold", 32'(bulls), 32'h1);
        check("done_cows_hold", 32'(cows), 32'h2);

        // Leaving the result screen mid-reveal aborts it.
        state = S_SCORE;
        tick();
        state = S_SHOW_RESULT;
        guess = 16'h1325;
        tick();
        reveal_start = 1'b1;
        tick();
        reveal_start = 1'b0;
        check("restart_bulls_clr", 32'(bulls), 32'h0);
        check("restart_cows_clr", 32'(cows), 32'h0);
        repeat (2) tick();
        check("mid_bulls", 32'(bulls), 32'h1);
        state = S_WIN;
        tick();
        check("abort_done", 32'(reveal_done), 32'h0);
        check("abort_bulls_hold", 32'(bulls), 32'h1);
        check("abort_cows_hold", 32'(cows), 32'h0);
        check("abort_win_char", 32'(char_out), 32'h4A0B);
        state = S_SHOW_RESULT;
        tick();
        check("abort_fb_clear", 32'(led[8:5]), 32'h0);
        check("abort_live_guess", 32'(char_out), 32'h1325);
        tick();
        check("abort_still_idle", 32'(reveal_done), 32'h0);

        // Asynchronous reset in the middle of a reveal.
        reveal_start = 1'b1;
        tick();
        reveal_start = 1'b0;
        repeat (3) tick();
        check("pre_rst_bulls", 32'(bulls), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_char", 32'(char_out), 32'h0000_FFFF);
        check("arst_led", 32'(led), 32'h0);
        check("arst_bulls", 32'(bulls), 32'h0);
        check("arst_cows", 32'(cows), 32'h0);
        check("arst_done", 32'(reveal_done), 32'h0);
        state = S_IDLE;
        tick();
        rst = 1'b0;
        model_reset();
        apply_vec(vecs[8]);
        check("post_rst_done", 32'(reveal_done), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
